lcd_frame_arbiter: RTL

Shares the 16x2 character LCD between several game-logic requesters. It keeps a double-buffered 32-character frame. Requesters write single cells into the back buffer through a round-robin arbitrated valid/ready port. A commit copies the back buffer into the front buffer in one cycle. The front buffer drives the `row_1`/`row_2` inputs of the `lcd1602` driver, so the panel never shows a half-updated frame.

---
 rtl/lcd_frame_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/lcd_frame_arbiter.sv
// Double-buffered 16x2 LCD frame shared by NUM_REQ round-robin writers.
// Back buffer takes cell writes; commit copies it atomically to the displayed front buffer.
module lcd_frame_arbiter #(
    parameter int         NUM_REQ    = 3,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [5*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_char,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   clear_start,
    input  logic                   commit,
    output logic                   busy,
    output logic                   commit_done,
    output logic [127:0]           row_1,
    output logic [127:0]           row_2
);
    localparam int          PW = $clog2(NUM_REQ);
    localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state, state_nxt;
    logic [7:0]    bb [32];
    logic [7:0]    fb [32];
    logic [PW-1:0] ptr, gnt_idx;
    logic [PW:0]   cand;
    logic          gnt_any;
    logic [4:0]    cidx, cidx_nxt;
    logic          commit_pend, pend_nxt, do_commit;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [7:0]    wr_char;

    // Rotating priority: first valid at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= NR) cand = cand - NR;
            if (!gnt_any && req_valid[cand[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        wr_addr = '0;
        wr_char = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                wr_addr = req_addr[5*i +: 5];
                wr_char = req_char[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cidx_nxt  = cidx;
        req_ready = '0;
        wr_en     = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                wr_en = gnt_any;
                for (int i = 0; i < NUM_REQ; i++)
                    req_ready[i] = gnt_any && (gnt_idx == PW'(i));
                if (clear_start) begin
                    state_nxt = CLEAR;
                    cidx_nxt  = '0;
                end
            end
            CLEAR: begin
                busy     = 1'b1;
                cidx_nxt = cidx + 5'd1;
                if (cidx == 5'd31) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Commits seen during a sweep are held and applied once the sweep ends.
    always_comb begin
        do_commit = (state == IDLE) && (commit || commit_pend);
        pend_nxt  = commit_pend;
        if (state == CLEAR && commit) pend_nxt = 1'b1;
        else if (do_commit)           pend_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cidx        <= '0;
            commit_pend <= 1'b0;
            commit_done <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                bb[i] <= BLANK_CHAR;
                fb[i] <= BLANK_CHAR;
            end
        end else begin
            state       <= state_nxt;
            cidx        <= cidx_nxt;
            commit_pend <= pend_nxt;
            commit_done <= do_commit;
            if (do_commit)
                for (int i = 0; i < 32; i++) fb[i] <= bb[i];
            if (state == CLEAR) begin
                bb[cidx] <= BLANK_CHAR;
            end else if (wr_en) begin
                bb[wr_addr] <= wr_char;
                ptr <= (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + PW'(1);
            end
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_row
        assign row_1[127-8*i -: 8] = fb[i];
        assign row_2[127-8*i -: 8] = fb[16+i];
    end

endmodule
